edge_accum_scan: RTL and testbench
==================================

# edge_accum_scan

Parametrised sticky edge-mask accumulator for the primitive-check datapath. It ORs NCH channels of CH_W-bit edge masks into an internal accumulator and serves the accumulated bits two ways: random-access WORD_W-bit reads, and a scan engine that streams only non-zero words with their addresses over a valid/ready handshake. It adds a synchronous clear and hit statistics, and it generalises the fixed 8×512/32 accumulate-and-select block.

## Interface
- NCH, 8, number of mask channels
- CH_W, 512, bits per channel
- WORD_W, 32, readout word width; NCH*CH_W must be a multiple of WORD_W
- Derived: TOT_W = NCH*CH_W; NWORDS = TOT_W/WORD_W; AW = clog2(NWORDS)
- CLK  in  1  clock, all logic on rising edge
- RST_n  in  1  reset, synchronous, active-low
- mask_in  in  TOT_W  channel c at bits [c*CH_W +: CH_W]
- mask_vld  in  1  accumulate mask_in this cycle
- clr_req  in  1  clear the accumulator (single-cycle pulse or level)
- rd_addr  in  AW  word index for random read
- rd_data  out  WORD_W  accumulator word rd_addr, registered
- any_hit  out  1  OR of all accumulator bits, registered
- scan_start  in  1  begin a scan; ignored unless idle
- scan_busy  out  1  scan FSM not in IDLE
- out_vld  out  1  scan word available
- out_rdy  in  1  consumer accepts scan word
- out_addr  out  AW  index of emitted word
- out_data  out  WORD_W  emitted word (non-zero)
- scan_cnt  out  AW+1  non-zero words emitted in the current or last scan
- scan_done  out  1  one-cycle pulse at the end of a scan
- scan_abort  out  1  valid with scan_done; 1 if the scan was ended by clr_req

## Operation
- Accumulator acc[TOT_W]: clr_req → all zero (priority); else mask_vld → acc | mask_in; else hold. Accumulation continues during a scan.
- Random read: rd_data <= acc word rd_addr. If rd_addr ≥ NWORDS, rd_data is 0.
- any_hit <= |acc. The next-state value of acc is not used.
- Scan FSM states: IDLE, SCAN, EMIT, DONE.
  - IDLE: on scan_start, set idx=0 and scan_cnt=0, then go to SCAN.
  - SCAN: examine the live word acc[idx]. If non-zero, latch out_addr=idx and out_data=word, then go to EMIT. If zero and idx=NWORDS-1, go to DONE. If zero otherwise, idx++.
  - EMIT: out_vld=1 and the outputs are stable until out_rdy. On the handshake, scan_cnt++; then if idx=NWORDS-1 go to DONE, else idx++ and go to SCAN.
  - DONE: scan_done=1 for one cycle, scan_abort=0, then go to IDLE.
- clr_req in SCAN or EMIT: acc is cleared and out_vld drops the next cycle. The FSM goes to DONE with scan_abort=1. scan_cnt keeps the count of words already accepted.
- scan_start while scan_busy: ignored. scan_start and clr_req in the same cycle from IDLE: the clear applies and the scan starts; the scan sees zeros.
- Bits that arrive in a word after it has been scanned are not emitted in this scan.

## Timing
- Reset values: acc=0, rd_data=0, any_hit=0, state=IDLE, out_vld=0, out_addr=0, out_data=0, scan_cnt=0, scan_done=0, scan_abort=0, scan_busy=0.
- Reset mid-scan: returns to IDLE at once. No scan_done pulse.
- mask_vld at edge t → visible in acc after t. rd_addr at t+1 → rd_data at t+2. any_hit rises at t+2.
- scan_start sampled at edge t → SCAN with idx 0 during cycle t+1. Each zero word costs 1 cycle. Each non-zero word costs 1 SCAN cycle plus ≥1 EMIT cycle.
- Empty accumulator: scan_done during cycle t+NWORDS+1. scan_busy=1 from t+1 through t+NWORDS+1.
- out_vld never depends on out_rdy in the same cycle.

## Structure
- Package edge_accum_pkg holds:
  - the scan-state enum type
  - the clog2-based AW/NWORDS derivation function
  - the default parameter constants
- Sub-module edge_scan_fsm: state register, idx, scan_cnt, and the handshake. It takes the selected word acc[idx] as an input.
- The top level holds acc, the random-read mux, and any_hit.

## Test plan
All scenarios use the defaults: NCH=8, CH_W=512, WORD_W=32, NWORDS=128.
- Reset, then mask_in bit 0 = 1 and channel-7 bit 511 = 1 with mask_vld → rd_addr 0 reads 0x00000001; rd_addr 127 reads 0x80000000; any_hit=1.
- Two accumulations 0x0F then 0xF0 into word 5, then clr_req → word 5 reads 0xFF before the clear and 0 after; any_hit returns to 0.
- Empty accumulator, scan_start → no out_vld; scan_done with scan_abort=0 exactly 129 cycles after the start edge; scan_cnt=0.
- Words 3, 64 and 127 non-zero; out_rdy toggled randomly → out_addr sequence is 3, 64, 127; data is held while out_rdy=0; scan_cnt=3.
- clr_req while out_vld is held at addr 64 → out_vld drops; scan_done with scan_abort=1; scan_cnt=1.
- scan_start repeated while busy, plus mask_vld into a word already scanned → scan unaffected; the new bits are readable by random read.

Source files
------------

// File: rtl/edge_accum_pkg.sv
// Shared types, default parameters and size helpers for the edge-mask
// accumulator and its scan engine.
package edge_accum_pkg;

   localparam int NCH_DEF    = 8;
   localparam int CH_W_DEF   = 512;
   localparam int WORD_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_EMIT = 2'd2,
      ST_DONE = 2'd3
   } scan_state_e;

   function automatic int calc_nwords(input int tot_w, input int word_w);
      return tot_w / word_w;
   endfunction

   // A single-word accumulator still gets a 1-bit address so ports never collapse.
   function automatic int calc_aw(input int nwords);
      return (nwords > 1) ? $clog2(nwords) : 1;
   endfunction

endpackage

// File: rtl/edge_accum_scan_fsm.sv
// Scan engine: walks the accumulator word by word and streams non-zero words
// with their index over a valid/ready handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for scan_start
// SCAN  | examine live word at idx; latch it if non-zero
// EMIT  | present latched word until the consumer accepts it
// DONE  | one-cycle end-of-scan pulse, abort flag qualifies it
module edge_scan_fsm
   import edge_accum_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int NWORDS = 128,
   parameter int AW     = 7
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              clr_req_i,
   input  logic              scan_start_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic              out_rdy_i,
   output logic [AW-1:0]     idx_o,
   output logic              scan_busy_o,
   output logic              out_vld_o,
   output logic [AW-1:0]     out_addr_o,
   output logic [WORD_W-1:0] out_data_o,
   output logic [AW:0]       scan_cnt_o,
   output logic              scan_done_o,
   output logic              scan_abort_o
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NWORDS - 1);

   scan_state_e       state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              abort_q, abort_d;

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      abort_d = abort_q;
      case (state_q)
         ST_IDLE: begin
            if (scan_start_i) begin
               idx_d   = '0;
               cnt_d   = '0;
               abort_d = 1'b0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (clr_req_i) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else if (word_i != '0) begin
               addr_d  = idx_q;
               data_d  = word_i;
               state_d = ST_EMIT;
            end else if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         ST_EMIT: begin
            // A word handed over in the same cycle as a clear still counts.
            if (out_rdy_i) begin
               cnt_d = cnt_q + (AW+1)'(1);
            end
            if (clr_req_i) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else if (out_rdy_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = ST_SCAN;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign idx_o        = idx_q;
   assign scan_busy_o  = (state_q != ST_IDLE);
   assign out_vld_o    = (state_q == ST_EMIT);
   assign out_addr_o   = addr_q;
   assign out_data_o   = data_q;
   assign scan_cnt_o   = cnt_q;
   assign scan_done_o  = (state_q == ST_DONE);
   assign scan_abort_o = (state_q == ST_DONE) && abort_q;

endmodule

// File: rtl/edge_accum_scan.sv
// Sticky edge-mask accumulator with registered random-access readout,
// a global hit flag, and a non-zero-word scan engine.
module edge_accum_scan
   import edge_accum_pkg::*;
#(
   parameter int  NCH    = NCH_DEF,
   parameter int  CH_W   = CH_W_DEF,
   parameter int  WORD_W = WORD_W_DEF,
   localparam int TOT_W  = NCH * CH_W,
   localparam int NWORDS = calc_nwords(TOT_W, WORD_W),
   localparam int AW     = calc_aw(NWORDS)
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic [TOT_W-1:0]  mask_in_i,
   input  logic              mask_vld_i,
   input  logic              clr_req_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [WORD_W-1:0] rd_data_o,
   output logic              any_hit_o,
   input  logic              scan_start_i,
   output logic              scan_busy_o,
   output logic              out_vld_o,
   input  logic              out_rdy_i,
   output logic [AW-1:0]     out_addr_o,
   output logic [WORD_W-1:0] out_data_o,
   output logic [AW:0]       scan_cnt_o,
   output logic              scan_done_o,
   output logic              scan_abort_o
);

   localparam logic [AW:0] NWORDS_W = (AW+1)'(NWORDS);

   logic [TOT_W-1:0]  acc_q, acc_d;
   logic [WORD_W-1:0] rd_data_q, rd_data_d;
   logic              any_hit_q;
   logic [WORD_W-1:0] acc_words [NWORDS];
   logic [AW-1:0]     scan_idx;
   logic [WORD_W-1:0] scan_word;

   for (genvar w = 0; w < NWORDS; w++) begin : g_words
      assign acc_words[w] = acc_q[w*WORD_W +: WORD_W];
   end

   always_comb begin
      acc_d = acc_q;
      if (clr_req_i) begin
         acc_d = '0;
      end else if (mask_vld_i) begin
         acc_d = acc_q | mask_in_i;
      end
   end

   always_comb begin
      rd_data_d = '0;
      if ({1'b0, rd_addr_i} < NWORDS_W) begin
         rd_data_d = acc_words[rd_addr_i];
      end
   end

   // Readout and hit flag look at the registered accumulator, never acc_d.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         acc_q     <= '0;
         rd_data_q <= '0;
         any_hit_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         rd_data_q <= rd_data_d;
         any_hit_q <= |acc_q;
      end
   end

   assign rd_data_o = rd_data_q;
   assign any_hit_o = any_hit_q;
   assign scan_word = acc_words[scan_idx];

   edge_scan_fsm #(
      .WORD_W (WORD_W),
      .NWORDS (NWORDS),
      .AW     (AW)
   ) u_scan (
      .CLK          (CLK),
      .RST_n        (RST_n),
      .clr_req_i    (clr_req_i),
      .scan_start_i (scan_start_i),
      .word_i       (scan_word),
      .out_rdy_i    (out_rdy_i),
      .idx_o        (scan_idx),
      .scan_busy_o  (scan_busy_o),
      .out_vld_o    (out_vld_o),
      .out_addr_o   (out_addr_o),
      .out_data_o   (out_data_o),
      .scan_cnt_o   (scan_cnt_o),
      .scan_done_o  (scan_done_o),
      .scan_abort_o (scan_abort_o)
   );

endmodule

// File: tb/tb_edge_accum_scan.sv
// Bench for edge_accum_scan: word-array reference model, scan expectations
// queued at scan start and checked by an independent monitor.
module tb_edge_accum_scan;

   localparam int TOT_W  = 4096;
   localparam int WORD_W = 32;
   localparam int NWORDS = 128;
   localparam int AW     = 7;

   logic              CLK = 1'b0;
   logic              RST_n = 1'b0;
   logic [TOT_W-1:0]  mask_in = '0;
   logic              mask_vld = 1'b0;
   logic              clr_req = 1'b0;
   logic [AW-1:0]     rd_addr = '0;
   logic [WORD_W-1:0] rd_data;
   logic              any_hit;
   logic              scan_start = 1'b0;
   logic              scan_busy;
   logic              out_vld;
   logic              out_rdy = 1'b0;
   logic [AW-1:0]     out_addr;
   logic [WORD_W-1:0] out_data;
   logic [AW:0]       scan_cnt;
   logic              scan_done;
   logic              scan_abort;

   edge_accum_scan dut (
      .CLK          (CLK),
      .RST_n        (RST_n),
      .mask_in_i    (mask_in),
      .mask_vld_i   (mask_vld),
      .clr_req_i    (clr_req),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data),
      .any_hit_o    (any_hit),
      .scan_start_i (scan_start),
      .scan_busy_o  (scan_busy),
      .out_vld_o    (out_vld),
      .out_rdy_i    (out_rdy),
      .out_addr_o   (out_addr),
      .out_data_o   (out_data),
      .scan_cnt_o   (scan_cnt),
      .scan_done_o  (scan_done),
      .scan_abort_o (scan_abort)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [AW-1:0]     addr;
      logic [WORD_W-1:0] data;
   } exp_t;

   logic [WORD_W-1:0] model [NWORDS];
   exp_t exp_q[$];
   int   exp_cnt = 0;
   bit   exp_abort = 1'b0;
   int   done_count = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   rdy_rand = 1'b0;
   bit   rdy_man = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Single driver for out_rdy; runs after the stimulus has settled.
   initial begin
      forever begin
         @(posedge CLK);
         #2;
         out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_man;
      end
   end

   always @(negedge CLK) begin
      if (RST_n) begin
         if (out_vld) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scan_unexpected: out_vld with addr %0d, none expected", out_addr);
            end else begin
               check("scan_addr", 64'(out_addr), 64'(exp_q[0].addr));
               check("scan_data", 64'(out_data), 64'(exp_q[0].data));
               if (out_rdy) void'(exp_q.pop_front());
            end
         end
         if (scan_done) begin
            check("scan_cnt", 64'(scan_cnt), 64'(exp_cnt));
            check("scan_abort", 64'(scan_abort), 64'(exp_abort));
            if (!exp_abort) check("scan_leftover", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            done_count++;
         end
      end
   end

   task automatic model_clear();
      for (int w = 0; w < NWORDS; w++) model[w] = '0;
   endtask

   task automatic do_clear();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      model_clear();
   endtask

   task automatic acc_word(input int w, input logic [WORD_W-1:0] v);
      mask_in = '0;
      mask_in[w*WORD_W +: WORD_W] = v;
      mask_vld = 1'b1;
      tick();
      mask_vld = 1'b0;
      mask_in = '0;
      model[w] = model[w] | v;
   endtask

   task automatic read_check(input string name, input int w);
      rd_addr = AW'(w);
      tick();
      check(name, 64'(rd_data), 64'(model[w]));
   endtask

   // Expected stream: every non-zero word of the model, in ascending index order.
   task automatic prep_scan();
      exp_q.delete();
      exp_cnt = 0;
      exp_abort = 1'b0;
      for (int w = 0; w < NWORDS; w++) begin
         if (model[w] != '0) begin
            exp_q.push_back('{addr: AW'(w), data: model[w]});
            exp_cnt++;
         end
      end
   endtask

   task automatic wait_done_since(input int d0, input int budget, input string name);
      int n;
      n = 0;
      while (done_count == d0 && n < budget) begin
         tick();
         n++;
      end
      if (done_count == d0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scan_done not seen within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_front(input int addr, input int budget, input string name);
      int n;
      n = 0;
      while (!(exp_q.size() > 0 && int'(exp_q[0].addr) == addr) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: addr %0d never became next expected", name, addr);
      end
   endtask

   initial begin
      int n, d0, first;
      logic [WORD_W-1:0] v;
      model_clear();

      repeat (3) tick();
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_any_hit", 64'(any_hit), 64'd0);
      check("rst_busy", 64'(scan_busy), 64'd0);
      check("rst_out_vld", 64'(out_vld), 64'd0);
      check("rst_scan_cnt", 64'(scan_cnt), 64'd0);
      check("rst_scan_done", 64'(scan_done), 64'd0);
      RST_n = 1'b1;
      tick();

      // Lowest and highest accumulator bits.
      mask_in = '0;
      mask_in[0] = 1'b1;
      mask_in[TOT_W-1] = 1'b1;
      mask_vld = 1'b1;
      tick();
      mask_vld = 1'b0;
      mask_in = '0;
      check("acc_lo_any_hit_lag", 64'(any_hit), 64'd0);
      model[0] = 32'h0000_0001;
      model[NWORDS-1] = 32'h8000_0000;
      read_check("rd_word0", 0);
      check("any_hit_set", 64'(any_hit), 64'd1);
      read_check("rd_word127", NWORDS-1);

      // Accumulate then clear.
      do_clear();
      acc_word(5, 32'h0000_000F);
      acc_word(5, 32'h0000_00F0);
      read_check("rd_word5_acc", 5);
      check("rd_word5_ff", 64'(rd_data), 64'h0000_00FF);
      do_clear();
      read_check("rd_word5_clr", 5);
      tick();
      check("any_hit_clr", 64'(any_hit), 64'd0);

      // Empty scan: DONE entered on the NWORDS-th edge after the start edge.
      prep_scan();
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      check("empty_busy_first", 64'(scan_busy), 64'd1);
      n = 0;
      first = -1;
      while (first < 0 && n < 300) begin
         tick();
         n++;
         if (scan_done) first = n;
      end
      check("empty_done_cycle", 64'(first), 64'(NWORDS));
      tick();
      check("empty_busy_end", 64'(scan_busy), 64'd0);

      // Words 3, 64, 127 with random ready; restart attempts and late bits into word 3.
      acc_word(3, 32'($urandom()) | 32'h1);
      acc_word(64, 32'($urandom()) | 32'h10);
      acc_word(127, 32'($urandom()) | 32'h8000_0000);
      prep_scan();
      check("three_exp_cnt", 64'(exp_cnt), 64'd3);
      rdy_rand = 1'b1;
      d0 = done_count;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      wait_front(64, 2000, "three_wait64");
      scan_start = 1'b1;
      tick();
      tick();
      scan_start = 1'b0;
      acc_word(3, 32'h0F00_0000);
      wait_done_since(d0, 3000, "three_done");
      rdy_rand = 1'b0;
      read_check("rd_word3_late", 3);

      // Clear while word 64 is held.
      do_clear();
      acc_word(3, 32'hA5A5_0001);
      acc_word(64, 32'h0000_4000);
      acc_word(127, 32'h1234_5678);
      prep_scan();
      rdy_man = 1'b1;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      wait_front(64, 1000, "abort_wait64");
      rdy_man = 1'b0;
      n = 0;
      while (!out_vld && n < 500) begin
         tick();
         n++;
      end
      check("abort_vld_held", 64'(out_vld), 64'd1);
      repeat (3) tick();
      exp_cnt = 1;
      exp_abort = 1'b1;
      d0 = done_count;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      model_clear();
      check("abort_vld_drop", 64'(out_vld), 64'd0);
      wait_done_since(d0, 10, "abort_done");
      tick();
      check("abort_any_hit", 64'(any_hit), 64'd0);

      // Randomised fills and scans.
      for (int it = 0; it < 4; it++) begin
         do_clear();
         for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
            mask_in = '0;
            for (int j = 0; j < 4; j++) begin
               int w;
               w = int'($urandom_range(0, NWORDS-1));
               v = 32'($urandom()) & 32'($urandom());
               mask_in[w*WORD_W +: WORD_W] = mask_in[w*WORD_W +: WORD_W] | v;
               model[w] = model[w] | v;
            end
            mask_vld = 1'b1;
            tick();
            mask_vld = 1'b0;
            mask_in = '0;
         end
         read_check("rand_rd", int'($urandom_range(0, NWORDS-1)));
         prep_scan();
         rdy_rand = 1'b1;
         d0 = done_count;
         scan_start = 1'b1;
         tick();
         scan_start = 1'b0;
         wait_done_since(d0, 5000, "rand_done");
         rdy_rand = 1'b0;
      end

      // Reset mid-scan returns straight to idle.
      do_clear();
      acc_word(10, 32'h1);
      prep_scan();
      rdy_man = 1'b0;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      repeat (20) tick();
      RST_n = 1'b0;
      tick();
      check("midrst_busy", 64'(scan_busy), 64'd0);
      check("midrst_vld", 64'(out_vld), 64'd0);
      check("midrst_done", 64'(scan_done), 64'd0);
      exp_q.delete();
      model_clear();
      RST_n = 1'b1;
      read_check("midrst_rd10", 10);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
